// File: rtl/hsv_core_commit_writeback.sv
// Purpose: in-order commit stage; regfile writeback, retire, jump/trap flush + PC redirect.
// Latency: all outputs registered, effects visible 1 cycle after accept.
// Backpressure: ready_o low from a jump/trap accept until every flush_ack has dropped again.
// Optional feature macro: HSV_COMMIT_RETIRE_COUNT_EN adds retire_count/retire_pulse outputs.

package hsv_core_commit_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd_addr;
  } commit_common_t;

  typedef struct packed {
    logic           jump;
    logic           trap;
    commit_common_t common;
    logic [31:0]    result;
    logic [31:0]    next_pc;
    logic           writeback;
  } commit_data_t;

endpackage

module hsv_core_commit_writeback
  import hsv_core_commit_pkg::*;
#(
  parameter int          NUM_FLUSH_ACKS = 1,
  parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0100
) (
  input  logic                      clk_core,
  input  logic                      rst_core_n,
  input  commit_data_t              commit_data,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic                      rf_wr_en,
  output logic [4:0]                rf_wr_addr,
  output logic [31:0]               rf_wr_data,
  output logic                      flush_req,
  input  logic [NUM_FLUSH_ACKS-1:0] flush_ack,
  output logic                      redirect_valid,
  output logic [31:0]               redirect_pc,
  output logic                      trap_valid,
`ifdef HSV_COMMIT_RETIRE_COUNT_EN
  output logic [31:0]               trap_pc,
  output logic [63:0]               retire_count,
  output logic                      retire_pulse
`else
  output logic [31:0]               trap_pc
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        flush_start;
  logic [31:0] target_q;
  logic        trap_q;

  // State register
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: DRAIN waits for all acks to fall so a stale ack cannot end the next flush
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_start) state_d = FLUSH;
      FLUSH:   if (&flush_ack) state_d = DRAIN;
      DRAIN:   if (!(|flush_ack)) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Handshake decode, purely from the state register
  always_comb begin
    ready_o     = (state_q == RUN);
    accept      = valid_i & ready_o;
    flush_start = accept & (commit_data.trap | commit_data.jump);
  end

  // Registered writeback, flush request and redirect outputs
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      rf_wr_en       <= 1'b0;
      rf_wr_addr     <= '0;
      rf_wr_data     <= '0;
      flush_req      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      trap_valid     <= 1'b0;
      trap_pc        <= '0;
      target_q       <= '0;
      trap_q         <= 1'b0;
    end else begin
      rf_wr_en       <= 1'b0;
      redirect_valid <= 1'b0;
      trap_valid     <= 1'b0;
      case (state_q)
        RUN: begin
          if (accept) begin
            if (commit_data.trap) begin
              // Trap suppresses the write even when writeback/jump are also set
              trap_pc   <= commit_data.common.pc;
              target_q  <= TRAP_VECTOR;
              trap_q    <= 1'b1;
              flush_req <= 1'b1;
            end else begin
              rf_wr_en   <= commit_data.writeback & (commit_data.common.rd_addr != 5'd0);
              rf_wr_addr <= commit_data.common.rd_addr;
              rf_wr_data <= commit_data.result;
              if (commit_data.jump) begin
                target_q  <= commit_data.next_pc;
                trap_q    <= 1'b0;
                flush_req <= 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          if (&flush_ack) begin
            flush_req      <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= target_q;
            trap_valid     <= trap_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HSV_COMMIT_RETIRE_COUNT_EN
  // Retire counter: every accepted non-trap instruction, jumps included
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      retire_count <= '0;
      retire_pulse <= 1'b0;
    end else begin
      retire_pulse <= accept & ~commit_data.trap;
      if (accept && !commit_data.trap) begin
        retire_count <= retire_count + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hsv_core_commit_writeback.sv
module tb_hsv_core_commit_writeback;
  import hsv_core_commit_pkg::*;

  localparam logic [31:0] TV = 32'h0000_0100;

  logic         clk_core = 1'b0;
  logic         rst_core_n = 1'b0;
  commit_data_t commit_data;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic         rf_wr_en;
  logic [4:0]   rf_wr_addr;
  logic [31:0]  rf_wr_data;
  logic         flush_req;
  logic [1:0]   flush_ack = 2'b00;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         trap_valid;
  logic [31:0]  trap_pc;
`ifdef HSV_COMMIT_RETIRE_COUNT_EN
  logic [63:0]  retire_count;
  logic         retire_pulse;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk_core = ~clk_core;

  hsv_core_commit_writeback #(
    .NUM_FLUSH_ACKS(2),
    .TRAP_VECTOR(TV)
  ) dut (
    .clk_core(clk_core),
    .rst_core_n(rst_core_n),
    .commit_data(commit_data),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .rf_wr_en(rf_wr_en),
    .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .flush_req(flush_req),
    .flush_ack(flush_ack),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .trap_valid(trap_valid),
`ifdef HSV_COMMIT_RETIRE_COUNT_EN
    .trap_pc(trap_pc),
    .retire_count(retire_count),
    .retire_pulse(retire_pulse)
`else
    .trap_pc(trap_pc)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic jump, input logic trap, input logic wb, input logic [4:0] rd,
                      input logic [31:0] pc, input logic [31:0] result, input logic [31:0] npc);
    commit_data.jump           = jump;
    commit_data.trap           = trap;
    commit_data.writeback      = wb;
    commit_data.common.rd_addr = rd;
    commit_data.common.pc      = pc;
    commit_data.result         = result;
    commit_data.next_pc        = npc;
    valid_i                    = 1'b1;
  endtask

  // Advance one clock and land 1 time unit after the edge
  task automatic cyc();
    @(posedge clk_core);
    #1;
  endtask

  initial begin
    commit_data = '0;
    // Reset values
    #12;
    chk("rst_ready", ready_o, 1);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_wr_addr", rf_wr_addr, 0);
    chk("rst_wr_data", rf_wr_data, 0);
    chk("rst_flush", flush_req, 0);
    chk("rst_redir", redirect_valid, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    chk("rst_trap_v", trap_valid, 0);
    chk("rst_trap_pc", trap_pc, 0);
    rst_core_n = 1'b1;
    cyc();

    // Writeback to x5, then to x0 (suppressed)
    beat(0, 0, 1, 5'd5, 32'h10, 32'hDEAD_BEEF, 32'h14);
    cyc();
    chk("wb_en", rf_wr_en, 1);
    chk("wb_addr", rf_wr_addr, 5);
    chk("wb_data", rf_wr_data, 32'hDEAD_BEEF);
    beat(0, 0, 1, 5'd0, 32'h14, 32'h1234_5678, 32'h18);
    cyc();
    chk("x0_en", rf_wr_en, 0);
    valid_i = 1'b0;
    cyc();
    chk("idle_en", rf_wr_en, 0);

    // Four back-to-back beats
    for (int i = 0; i < 4; i++) begin
      beat(0, 0, 1, 5'(10 + i), 32'h20 + 32'(4 * i), 32'h100 + 32'(i), 32'h0);
      cyc();
      chk("strm_en", rf_wr_en, 1);
      chk("strm_addr", rf_wr_addr, 10 + i);
      chk("strm_data", rf_wr_data, 32'h100 + i);
      chk("strm_ready", ready_o, 1);
    end
    valid_i = 1'b0;
    cyc();
    chk("strm_end_en", rf_wr_en, 0);

    // Jump with link write, acks delayed; a held beat during the flush must not be taken
    beat(1, 0, 1, 5'd1, 32'h1000, 32'h1004, 32'h2000);
    cyc();
    chk("jmp_en", rf_wr_en, 1);
    chk("jmp_addr", rf_wr_addr, 1);
    chk("jmp_data", rf_wr_data, 32'h1004);
    chk("jmp_flush", flush_req, 1);
    chk("jmp_ready", ready_o, 0);
    beat(0, 0, 1, 5'd7, 32'h1004, 32'hBAD0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("jmp_wait_flush", flush_req, 1);
      chk("jmp_wait_en", rf_wr_en, 0);
      chk("jmp_wait_redir", redirect_valid, 0);
      chk("jmp_wait_ready", ready_o, 0);
    end
    flush_ack = 2'b11;
    cyc();
    chk("jmp_redir", redirect_valid, 1);
    chk("jmp_redir_pc", redirect_pc, 32'h2000);
    chk("jmp_trap_v", trap_valid, 0);
    chk("jmp_flush_off", flush_req, 0);
    chk("jmp_drain_ready", ready_o, 0);
    valid_i = 1'b0;
    cyc();
    chk("jmp_redir_1cyc", redirect_valid, 0);
    chk("jmp_ack_hi_ready", ready_o, 0);
    chk("jmp_held_en", rf_wr_en, 0);
    flush_ack = 2'b00;
    cyc();
    chk("jmp_back_ready", ready_o, 1);

    // Trap with writeback set: no write, redirect to trap vector
    beat(0, 1, 1, 5'd3, 32'h0000_0040, 32'h5555, 32'h44);
    cyc();
    chk("trp_en", rf_wr_en, 0);
    chk("trp_flush", flush_req, 1);
    valid_i = 1'b0;
    flush_ack = 2'b11;
    cyc();
    chk("trp_redir", redirect_valid, 1);
    chk("trp_redir_pc", redirect_pc, TV);
    chk("trp_trap_v", trap_valid, 1);
    chk("trp_trap_pc", trap_pc, 32'h40);
    chk("trp_en2", rf_wr_en, 0);
    cyc();
    chk("trp_trap_1cyc", trap_valid, 0);
    chk("trp_redir_1cyc", redirect_valid, 0);
    flush_ack = 2'b00;
    cyc();
    chk("trp_back_ready", ready_o, 1);

    // Acks in RUN are ignored
    flush_ack = 2'b11;
    cyc();
    chk("run_ack_flush", flush_req, 0);
    chk("run_ack_redir", redirect_valid, 0);
    chk("run_ack_ready", ready_o, 1);
    flush_ack = 2'b00;
    cyc();

    // Multi-ack: acks rise on different cycles, then fall on different cycles
    beat(1, 0, 0, 5'd2, 32'h2000, 32'h2004, 32'h3000);
    cyc();
    chk("ma_en", rf_wr_en, 0);
    chk("ma_flush", flush_req, 1);
    valid_i = 1'b0;
    flush_ack = 2'b01;
    cyc();
    chk("ma_partial_redir", redirect_valid, 0);
    chk("ma_partial_flush", flush_req, 1);
    flush_ack = 2'b11;
    cyc();
    chk("ma_redir", redirect_valid, 1);
    chk("ma_redir_pc", redirect_pc, 32'h3000);
    flush_ack = 2'b10;
    cyc();
    chk("ma_one_ack_ready", ready_o, 0);
    chk("ma_redir_1cyc", redirect_valid, 0);
    flush_ack = 2'b00;
    cyc();
    chk("ma_back_ready", ready_o, 1);

`ifdef HSV_COMMIT_RETIRE_COUNT_EN
    // 2 writeback beats + 4 stream + 2 jumps; the trap and held beat do not retire
    chk("retire_count", retire_count, 64'd8);
    chk("retire_pulse_idle", retire_pulse, 0);
`endif

    // Async reset in the middle of a flush
    beat(1, 0, 1, 5'd4, 32'h3000, 32'h3004, 32'h4000);
    cyc();
    chk("mr_flush", flush_req, 1);
    valid_i = 1'b0;
    #2;
    rst_core_n = 1'b0;
    #1;
    chk("mr_flush_off", flush_req, 0);
    chk("mr_ready", ready_o, 1);
    chk("mr_wr_en", rf_wr_en, 0);
    #1;
    rst_core_n = 1'b1;
    cyc();
    chk("mr_after_flush", flush_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
